kws_window_sched: RTL and testbench

//  Sliding-window scheduler for the CNN keyword-spotting accelerator. Writes incoming MFCC frames into the

---
 rtl/kws_window_sched.sv | 145 ++++++++++++++
 tb/tb_kws_window_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kws_window_sched.sv
// Sliding-window scheduler for the keyword-spotting accelerator. It fills the MFCC ring buffer,
// launches one inference per window or per hop, and returns the accelerator result as a pulse.
module kws_window_sched #(
  parameter int unsigned NUM_KEYWORDS = 10,
  parameter int unsigned MFCC_FRAMES  = 100,
  parameter int unsigned HOP_FRAMES   = 25,
  parameter int unsigned TIMEOUT_CYC  = 4096,
  localparam int unsigned AW = (MFCC_FRAMES > 1) ? $clog2(MFCC_FRAMES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    mfcc_valid,
  output logic                    mfcc_ready,
  output logic                    buf_wr_en,
  output logic [AW-1:0]           buf_wr_addr,
  output logic [AW-1:0]           win_base,
  output logic                    accel_start,
  input  logic                    accel_done,
  input  logic [NUM_KEYWORDS-1:0] accel_result,
  output logic [NUM_KEYWORDS-1:0] kws_result,
  output logic                    kws_valid,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int unsigned FW = $clog2(MFCC_FRAMES + 1);
  localparam int unsigned HW = $clog2(HOP_FRAMES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_FILL, S_START, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]           fill_cnt_q, fill_cnt_d;
  logic [HW-1:0]           hop_cnt_q, hop_cnt_d;
  logic                    primed_q, primed_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [AW-1:0]           win_base_d;
  logic [NUM_KEYWORDS-1:0] kws_result_d;
  logic                    kws_valid_d;
  logic                    err_timeout_d;
  logic                    hs;

  // Handshake-facing signals are decodes of the state register.
  assign mfcc_ready  = (state_q == S_FILL);
  assign accel_start = (state_q == S_START);
  assign busy        = (state_q == S_START) || (state_q == S_RUN);
  assign hs          = mfcc_valid && mfcc_ready;
  assign buf_wr_en   = hs;
  assign buf_wr_addr = wr_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      hop_cnt_q   <= '0;
      primed_q    <= 1'b0;
      timer_q     <= '0;
      win_base    <= '0;
      kws_result  <= '0;
      kws_valid   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      hop_cnt_q   <= hop_cnt_d;
      primed_q    <= primed_d;
      timer_q     <= timer_d;
      win_base    <= win_base_d;
      kws_result  <= kws_result_d;
      kws_valid   <= kws_valid_d;
      err_timeout <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    fill_cnt_d    = fill_cnt_q;
    hop_cnt_d     = hop_cnt_q;
    primed_d      = primed_q;
    timer_d       = timer_q;
    win_base_d    = win_base;
    kws_result_d  = kws_result;
    kws_valid_d   = 1'b0;
    err_timeout_d = err_timeout;

    case (state_q)
      S_FILL: begin
        if (hs) begin
          wr_ptr_d = (wr_ptr_q == AW'(MFCC_FRAMES - 1)) ? '0 : wr_ptr_q + AW'(1);
          if (!primed_q) begin
            fill_cnt_d = fill_cnt_q + FW'(1);
            if (fill_cnt_q == FW'(MFCC_FRAMES - 1)) begin
              primed_d = 1'b1;
              state_d  = S_START;
            end
          end else if (hop_cnt_q == HW'(HOP_FRAMES - 1)) begin
            hop_cnt_d = '0;
            state_d   = S_START;
          end else begin
            hop_cnt_d = hop_cnt_q + HW'(1);
          end
        end
      end
      S_START: begin
        // Write pointer has already advanced past the newest frame, so it marks the oldest.
        win_base_d = wr_ptr_q;
        timer_d    = '0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (accel_done) begin
          kws_result_d = accel_result;
          kws_valid_d  = 1'b1;
          state_d      = S_FILL;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = S_FILL;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_FILL;
    endcase

    // Flush overrides everything except the result register and the last window base.
    if (flush) begin
      state_d       = S_FILL;
      wr_ptr_d      = '0;
      fill_cnt_d    = '0;
      hop_cnt_d     = '0;
      primed_d      = 1'b0;
      timer_d       = '0;
      win_base_d    = win_base;
      kws_result_d  = kws_result;
      kws_valid_d   = 1'b0;
      err_timeout_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_kws_window_sched.sv
// Scoreboard bench for kws_window_sched: the driver queues expected writes, starts and results;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_kws_window_sched;

  localparam int unsigned NK = 10;
  localparam int unsigned AW = 7;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          mfcc_valid;
  logic          mfcc_ready;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [AW-1:0] win_base;
  logic          accel_start;
  logic          accel_done;
  logic [NK-1:0] accel_result;
  logic [NK-1:0] kws_result;
  logic          kws_valid;
  logic          busy;
  logic          err_timeout;

  kws_window_sched dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .mfcc_valid   (mfcc_valid),
    .mfcc_ready   (mfcc_ready),
    .buf_wr_en    (buf_wr_en),
    .buf_wr_addr  (buf_wr_addr),
    .win_base     (win_base),
    .accel_start  (accel_start),
    .accel_done   (accel_done),
    .accel_result (accel_result),
    .kws_result   (kws_result),
    .kws_valid    (kws_valid),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total;
  int unsigned passed;
  int          exp_addr[$];
  int          exp_start_hs[$];
  int          exp_start_wb[$];
  logic [NK-1:0] exp_res[$];
  int          ptr;
  int          hs_total;
  int          neg_cnt;
  int          last_hs_neg;
  logic        wb_pending;
  int          wb_exp;
  logic        prev_valid;
  int          exp_h;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pop and compare every write, start and result the DUT presents.
  always @(negedge clk) begin
    if (!rst) begin
      neg_cnt++;
      if (wb_pending) begin
        check("win_base", 32'(win_base), wb_exp);
        wb_pending = 1'b0;
      end
      if (accel_start) begin
        if (exp_start_hs.size() == 0) check("accel_start_unexpected", 32'(accel_start), 0);
        else begin
          exp_h      = exp_start_hs.pop_front();
          wb_exp     = exp_start_wb.pop_front();
          wb_pending = 1'b1;
          check("start_frame_count", hs_total, exp_h);
          check("start_latency", neg_cnt - last_hs_neg, 1);
        end
      end
      if (buf_wr_en) begin
        hs_total++;
        last_hs_neg = neg_cnt;
        if (exp_addr.size() == 0) check("write_unexpected", 32'(buf_wr_en), 0);
        else check("buf_wr_addr", 32'(buf_wr_addr), exp_addr.pop_front());
      end
      if (kws_valid) begin
        check("kws_valid_width", 32'(prev_valid), 0);
        if (exp_res.size() == 0) check("kws_valid_unexpected", 32'(kws_valid), 0);
        else check("kws_result", 32'(kws_result), 32'(exp_res.pop_front()));
      end
      prev_valid = kws_valid;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_start(input int hs_cnt, input int wb);
    exp_start_hs.push_back(hs_cnt);
    exp_start_wb.push_back(wb);
  endtask

  task automatic send(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(ptr);
      ptr = (ptr + 1) % 100;
      mfcc_valid = 1'b1;
      g = 0;
      while (!mfcc_ready && g < 100) begin
        @(posedge clk);
        #1;
        g++;
      end
      if (!mfcc_ready) check("ready_wait", 32'(mfcc_ready), 1);
      @(posedge clk);
      #1;
    end
    mfcc_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [NK-1:0] r, input logic fl);
    accel_result = r;
    accel_done   = 1'b1;
    flush        = fl;
    @(posedge clk);
    #1;
    accel_done   = 1'b0;
    flush        = 1'b0;
    accel_result = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    total = 0; passed = 0; ptr = 0; hs_total = 0; neg_cnt = 0; last_hs_neg = -10;
    wb_pending = 1'b0; wb_exp = 0; prev_valid = 1'b0;
    rst = 1'b1; flush = 1'b0; mfcc_valid = 1'b0; accel_done = 1'b0; accel_result = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_mfcc_ready", 32'(mfcc_ready), 1);
    check("reset_accel_start", 32'(accel_start), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_kws_result", 32'(kws_result), 0);
    check("reset_err_timeout", 32'(err_timeout), 0);
    check("reset_win_base", 32'(win_base), 0);

    // 1: first full window
    expect_start(100, 0);
    send(100);
    cycles(2);
    check("run_mfcc_ready", 32'(mfcc_ready), 0);
    check("run_busy", 32'(busy), 1);

    // 2: result return
    exp_res.push_back(10'h001);
    pulse_done(10'h001, 1'b0);
    check("post_done_ready", 32'(mfcc_ready), 1);
    cycles(1);

    // 3: primed hop with address wrap
    expect_start(125, 25);
    send(25);
    cycles(2);
    exp_res.push_back(10'h010);
    pulse_done(10'h010, 1'b0);
    cycles(1);

    // 4: timeout, stray done, restart
    expect_start(150, 50);
    send(25);
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("timeout_cycles", n, 4097);
    check("err_timeout_set", 32'(err_timeout), 1);
    pulse_done(10'h3FF, 1'b0);
    cycles(2);
    check("stray_done_result", 32'(kws_result), 32'(10'h010));
    expect_start(175, 75);
    send(25);
    cycles(2);
    exp_res.push_back(10'h004);
    pulse_done(10'h004, 1'b0);
    cycles(1);

    // 5: flush clears priming and error
    check("err_before_flush", 32'(err_timeout), 1);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    ptr = 0;
    check("err_after_flush", 32'(err_timeout), 0);
    send(60);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    ptr = 0;
    expect_start(335, 0);
    send(100);
    cycles(3);
    check("busy_before_flush_done", 32'(busy), 1);
    pulse_done(10'h155, 1'b1);
    cycles(2);
    check("flush_done_busy", 32'(busy), 0);
    check("flush_done_ready", 32'(mfcc_ready), 1);
    check("flush_done_result", 32'(kws_result), 32'(10'h004));

    // 6: async reset mid-run
    expect_start(435, 0);
    send(100);
    cycles(2);
    exp_res.push_back(10'h2AA);
    pulse_done(10'h2AA, 1'b0);
    cycles(1);
    expect_start(460, 25);
    send(25);
    cycles(3);
    #3 rst = 1'b1;
    #1;
    check("async_busy", 32'(busy), 0);
    check("async_accel_start", 32'(accel_start), 0);
    check("async_kws_result", 32'(kws_result), 0);
    check("async_win_base", 32'(win_base), 0);
    check("async_buf_wr_addr", 32'(buf_wr_addr), 0);
    check("async_kws_valid", 32'(kws_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    ptr = 0;
    #1;
    check("post_rst_ready", 32'(mfcc_ready), 1);
    expect_start(560, 0);
    send(99);
    cycles(2);
    check("refill_not_started", 32'(busy), 0);
    send(1);
    cycles(2);
    exp_res.push_back(10'h0F0);
    pulse_done(10'h0F0, 1'b0);
    cycles(3);

    check("writes_drained", exp_addr.size(), 0);
    check("starts_drained", exp_start_hs.size(), 0);
    check("results_drained", exp_res.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
